fp_std_1: RTL

FP_STD_1 -- requirements
Module: fp_std_1

---
 rtl/fp_pkg.sv | 32 +++
 rtl/fp_lzc16.sv | 22 ++
 rtl/fp_std_1.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the fp24 datapath blocks: field layout, op codes and
// the packed float type.
package fp_pkg;

    localparam int SIGN_BIT = 23;
    localparam int EXP_MSB  = 22;
    localparam int EXP_LSB  = 15;
    localparam int FRAC_W   = 15;
    localparam int BIAS     = 127;

    localparam logic [EXP_MSB-EXP_LSB:0] EXP_INF = 8'hFF;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_MIN = 4'b0001;
    localparam logic [3:0] OP_MAX = 4'b0010;

    typedef struct packed {
        logic                     sign;
        logic [EXP_MSB-EXP_LSB:0] exp;
        logic [FRAC_W-1:0]        frac;
    } fp24_t;

    // What stage 2 has to do with the operation held in stage 1.
    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,
        CLS_EADD = 2'd1,
        CLS_ESUB = 2'd2,
        CLS_PASS = 2'd3
    } cls_e;

endpackage

// File: rtl/fp_lzc16.sv
// Leading-zero counter for a 16-bit mantissa; an all-zero input reports count 0
// and raises all_zero_o.
module fp_lzc16 (
    input  logic [15:0] in_i,
    output logic [3:0]  cnt_o,
    output logic        all_zero_o
);

    logic [3:0] cnt;

    // Scanning upward lets the highest set bit win.
    always_comb begin
        cnt = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (in_i[i]) cnt = 4'(15 - i);
        end
    end

    assign cnt_o      = cnt;
    assign all_zero_o = (in_i == 16'h0000);

endmodule

// File: rtl/fp_std_1.sv
// fp24 add/sub normalise-and-pack back end plus MIN/MAX pass-through.
// Two-stage valid/ready pipeline: S1 holds classification and lz count, S2 the packed result.
module fp_std_1
    import fp_pkg::*;
#(
    parameter int WIDTH = 24
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [3:0]       op_i,
    input  logic [16:0]      add_mant_i,
    input  logic [15:0]      sub_mant_i,
    input  logic             max_sign_i,
    input  logic             min_sign_i,
    input  logic [WIDTH-1:0] max_result_i,
    input  logic [WIDTH-1:0] min_result_i,
    input  logic [7:0]       max_exp_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             overflow_o
);

    logic             s1_valid_d, s1_valid_q;
    logic             s2_valid_d, s2_valid_q;
    cls_e             s1_cls_d, s1_cls_q;
    logic             s1_sign_d, s1_sign_q;
    logic [7:0]       s1_exp_d, s1_exp_q;
    logic [16:0]      s1_mant_d, s1_mant_q;
    logic [3:0]       s1_lz_d, s1_lz_q;
    logic [WIDTH-1:0] s1_pass_d, s1_pass_q;
    logic [WIDTH-1:0] s2_result_d, s2_result_q;
    logic             s2_ovf_d, s2_ovf_q;

    logic        s1_advance, accept, s2_load;
    logic [3:0]  lz_cnt;
    logic        lz_zero;
    logic [15:0] mant_n;
    logic signed [9:0] exp_s;
    fp24_t       packed_res;
    logic        packed_ovf;

    fp_lzc16 u_lzc (
        .in_i       (sub_mant_i),
        .cnt_o      (lz_cnt),
        .all_zero_o (lz_zero)
    );

    assign s1_advance = !s2_valid_q || ready_i;
    assign ready_o    = !s1_valid_q || s1_advance;
    assign accept     = valid_i && ready_o;
    assign s2_load    = s1_valid_q && s1_advance;

    assign s1_valid_d = ready_o ? valid_i : s1_valid_q;
    assign s2_valid_d = s1_advance ? s1_valid_q : s2_valid_q;

    always_comb begin
        s1_cls_d  = CLS_ZERO;
        s1_sign_d = max_sign_i;
        s1_exp_d  = max_exp_i;
        s1_lz_d   = lz_cnt;
        s1_mant_d = add_mant_i;
        s1_pass_d = max_result_i;
        case (op_i)
            OP_ADD, OP_SUB: begin
                if (max_sign_i == min_sign_i) begin
                    s1_cls_d = (max_exp_i == 8'h00 && add_mant_i == 17'h0) ? CLS_ZERO : CLS_EADD;
                end else begin
                    s1_cls_d  = lz_zero ? CLS_ZERO : CLS_ESUB;
                    s1_mant_d = {1'b0, sub_mant_i};
                end
            end
            OP_MAX: s1_cls_d = CLS_PASS;
            OP_MIN: begin
                s1_cls_d  = CLS_PASS;
                s1_pass_d = min_result_i;
            end
            default: s1_cls_d = CLS_ZERO;
        endcase
    end

    // Exponent is carried as 10-bit signed so both underflow and the +1 carry are visible.
    always_comb begin
        mant_n     = s1_mant_q[15:0];
        exp_s      = signed'({2'b00, s1_exp_q});
        packed_res = '0;
        packed_ovf = 1'b0;
        if (s1_cls_q == CLS_EADD && s1_mant_q[16]) begin
            mant_n = s1_mant_q[16:1];
            exp_s  = exp_s + 10'sd1;
        end else if (s1_cls_q == CLS_ESUB) begin
            mant_n = s1_mant_q[15:0] << s1_lz_q;
            exp_s  = exp_s - signed'({6'b000000, s1_lz_q});
        end
        if (exp_s <= 10'sd0 || !mant_n[15]) begin
            packed_res.sign = s1_sign_q;
        end else if (exp_s >= 10'sd255) begin
            packed_res.sign = s1_sign_q;
            packed_res.exp  = EXP_INF;
            packed_ovf      = 1'b1;
        end else begin
            packed_res.sign = s1_sign_q;
            packed_res.exp  = exp_s[7:0];
            packed_res.frac = mant_n[FRAC_W-1:0];
        end
    end

    always_comb begin
        s2_result_d = s2_result_q;
        s2_ovf_d    = s2_ovf_q;
        if (s2_load) begin
            case (s1_cls_q)
                CLS_PASS: begin
                    s2_result_d = s1_pass_q;
                    s2_ovf_d    = 1'b0;
                end
                CLS_EADD, CLS_ESUB: begin
                    s2_result_d = WIDTH'(packed_res);
                    s2_ovf_d    = packed_ovf;
                end
                default: begin
                    s2_result_d = '0;
                    s2_ovf_d    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_ovf_q    <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_ovf_q    <= s2_ovf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            s1_cls_q  <= s1_cls_d;
            s1_sign_q <= s1_sign_d;
            s1_exp_q  <= s1_exp_d;
            s1_mant_q <= s1_mant_d;
            s1_lz_q   <= s1_lz_d;
            s1_pass_q <= s1_pass_d;
        end
    end

    assign valid_o    = s2_valid_q;
    assign result_o   = s2_result_q;
    assign overflow_o = s2_ovf_q;

endmodule
